// File: rtl/dmem_arbiter_if.sv
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Request/grant and RAM-side bundle for the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wd;
    logic [31:0] cpu_rd;
    logic        cpu_stall;
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wd;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [31:0] dma_rd;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic        err_oob;
    logic [31:0] err_addr;

    // Requesters and RAM side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wd,
        input  cpu_rd, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wd,
        input  dma_gnt, dma_rvalid, dma_rd,
        input  mem_we, mem_addr, mem_wd,
        output mem_rd,
        input  err_oob, err_addr
    );

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wd,
        output cpu_rd, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wd,
        output dma_gnt, dma_rvalid, dma_rd,
        output mem_we, mem_addr, mem_wd,
        input  mem_rd,
        output err_oob, err_addr
    );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module      : dmem_arbiter
// Description : CPU-priority arbiter for single-port data memory with DMA
//               starvation guard and out-of-range access blocking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int DEPTH        = 129600,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic     clk,
    input  wire logic     reset,
    dmem_arbiter_if.slave bus
);

    localparam logic [31:0] c_depth        = 32'(DEPTH);
    localparam logic [3:0]  c_starve_limit = 4'(STARVE_LIMIT);

    logic [3:0]  r_starve_cnt;
    logic        w_force;
    logic        w_dma_grant;
    logic        w_cpu_grant;
    logic        w_cpu_in_range;
    logic        w_dma_in_range;
    logic        w_sel_in_range;
    logic        w_any_grant;
    logic [31:0] w_sel_addr;

    always_comb begin
        w_force        = bus.dma_req && (r_starve_cnt >= c_starve_limit);
        w_dma_grant    = w_force || (bus.dma_req && !bus.cpu_req);
        w_cpu_grant    = bus.cpu_req && !w_dma_grant;
        w_cpu_in_range = bus.cpu_addr < c_depth;
        w_dma_in_range = bus.dma_addr < c_depth;
        w_any_grant    = w_cpu_grant || w_dma_grant;

        w_sel_addr     = 32'd0;
        w_sel_in_range = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = 32'd0;
        bus.mem_wd     = 32'd0;
        if (w_dma_grant) begin
            w_sel_addr     = bus.dma_addr;
            w_sel_in_range = w_dma_in_range;
            bus.mem_we     = bus.dma_we && w_dma_in_range;
            bus.mem_addr   = bus.dma_addr;
            bus.mem_wd     = bus.dma_wd;
        end else if (w_cpu_grant) begin
            w_sel_addr     = bus.cpu_addr;
            w_sel_in_range = w_cpu_in_range;
            bus.mem_we     = bus.cpu_we && w_cpu_in_range;
            bus.mem_addr   = bus.cpu_addr;
            bus.mem_wd     = bus.cpu_wd;
        end

        bus.cpu_stall = bus.cpu_req && !w_cpu_grant;
        bus.cpu_rd    = (w_cpu_grant && w_cpu_in_range) ? bus.mem_rd : 32'd0;
        bus.dma_gnt   = w_dma_grant;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt   <= 4'd0;
            bus.dma_rvalid <= 1'b0;
            bus.dma_rd     <= 32'd0;
            bus.err_oob    <= 1'b0;
            bus.err_addr   <= 32'd0;
        end else begin
            if (w_dma_grant || !bus.dma_req) begin
                r_starve_cnt <= 4'd0;
            end else if (r_starve_cnt != 4'hF) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end

            bus.dma_rvalid <= w_dma_grant && !bus.dma_we;
            if (w_dma_grant && !bus.dma_we) begin
                bus.dma_rd <= w_dma_in_range ? bus.mem_rd : 32'd0;
            end

            // Only the granted access can fault; the address is kept from the first one
            if (w_any_grant && !w_sel_in_range) begin
                bus.err_oob <= 1'b1;
                if (!bus.err_oob) begin
                    bus.err_addr <= w_sel_addr;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed table-driven bench for dmem_arbiter with a small RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    logic clk;
    logic reset;
    logic preload;
    int   n_checks;
    int   n_errors;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.DEPTH(129600), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 256-word RAM aliased on the low address byte; 129599 maps to 63, 129600/200000 to 64
    logic [31:0] ram [256];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'd0;
            ram[5]  <= 32'h0000_0012;
            ram[64] <= 32'h0000_0BAD;
        end else if (bus.mem_we) begin
            ram[bus.mem_addr[7:0]] <= bus.mem_wd;
        end
    end
    assign bus.mem_rd = ram[bus.mem_addr[7:0]];

    typedef struct {
        logic        rst;
        logic        creq;
        logic        cwe;
        logic [31:0] ca;
        logic [31:0] cw;
        logic        dreq;
        logic        dwe;
        logic [31:0] da;
        logic [31:0] dw;
        logic [164:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic row(input logic r, input logic creq, input logic cwe, input logic [31:0] ca, input logic [31:0] cw,
                       input logic dreq, input logic dwe, input logic [31:0] da, input logic [31:0] dw,
                       input logic stall, input logic gnt, input logic mwe, input logic [31:0] ma, input logic [31:0] mw,
                       input logic [31:0] crd, input logic rv, input logic [31:0] drd, input logic eo, input logic [31:0] ea);
        vec_t v;
        v.rst = r; v.creq = creq; v.cwe = cwe; v.ca = ca; v.cw = cw;
        v.dreq = dreq; v.dwe = dwe; v.da = da; v.dw = dw;
        v.exp = {stall, gnt, mwe, ma, mw, crd, rv, drd, eo, ea};
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        reset        = v.rst;
        bus.cpu_req  = v.creq;
        bus.cpu_we   = v.cwe;
        bus.cpu_addr = v.ca;
        bus.cpu_wd   = v.cw;
        bus.dma_req  = v.dreq;
        bus.dma_we   = v.dwe;
        bus.dma_addr = v.da;
        bus.dma_wd   = v.dw;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    logic [164:0] actual;
    int           win;

    localparam logic [31:0] D  = 32'hDEAD_BEEF;
    localparam logic [31:0] OB = 32'd129600;
    localparam logic [31:0] FR = 32'd200000;
    localparam logic [31:0] BD = 32'd129599;

    initial begin
        n_checks = 0;
        n_errors = 0;
        preload  = 1'b1;
        begin
            vec_t z;
            z = '{rst: 1'b1, creq: 1'b0, cwe: 1'b0, ca: 32'd0, cw: 32'd0, dreq: 1'b0, dwe: 1'b0, da: 32'd0, dw: 32'd0, exp: '0};
            drive(z);
        end

        //   rst creq cwe ca cw | dreq dwe da dw | stall gnt mwe maddr mwd crd rvalid drd eoob eaddr
        row(1, 1, 0, 7,   0,           1, 0, 9,   0,            0, 0, 0, 7,   0,            0,  0, 0,            0, 0);
        row(0, 1, 0, 7,   0,           1, 0, 9,   0,            0, 0, 0, 7,   0,            0,  0, 0,            0, 0);
        row(0, 0, 0, 0,   0,           0, 0, 0,   0,            0, 0, 0, 0,   0,            0,  0, 0,            0, 0);
        row(0, 1, 1, 100, D,           0, 0, 0,   0,            0, 0, 1, 100, D,            0,  0, 0,            0, 0);
        row(0, 1, 0, 100, 0,           0, 0, 0,   0,            0, 0, 0, 100, 0,            D,  0, 0,            0, 0);
        row(0, 0, 0, 0,   0,           1, 0, 5,   0,            0, 1, 0, 5,   0,            0,  0, 0,            0, 0);
        row(0, 0, 0, 0,   0,           0, 0, 0,   0,            0, 0, 0, 0,   0,            0,  1, 32'h12,       0, 0);
        for (int i = 0; i < 4; i++)
            row(0, 1, 0, 100, 0,       1, 1, 6, 32'hA5A5,       0, 0, 0, 100, 0,            D,  0, 32'h12,       0, 0);
        row(0, 1, 0, 100, 0,           1, 1, 6, 32'hA5A5,       1, 1, 1, 6, 32'hA5A5,       0,  0, 32'h12,       0, 0);
        row(0, 1, 0, 100, 0,           1, 0, 6, 0,              0, 0, 0, 100, 0,            D,  0, 32'h12,       0, 0);
        row(0, 0, 0, 0,   0,           1, 0, 6, 0,              0, 1, 0, 6,   0,            0,  0, 32'h12,       0, 0);
        row(0, 1, 1, OB,  32'h55,      0, 0, 0, 0,              0, 0, 0, OB,  32'h55,       0,  1, 32'hA5A5,     0, 0);
        row(0, 0, 0, 0,   0,           1, 1, FR, 32'h77,        0, 1, 0, FR,  32'h77,       0,  0, 32'hA5A5,     1, OB);
        row(0, 0, 0, 0,   0,           1, 0, FR, 0,             0, 1, 0, FR,  0,            0,  0, 32'hA5A5,     1, OB);
        row(0, 0, 0, 0,   0,           0, 0, 0,  0,             0, 0, 0, 0,   0,            0,  1, 0,            1, OB);
        row(0, 1, 0, OB,  0,           0, 0, 0,  0,             0, 0, 0, OB,  0,            0,  0, 0,            1, OB);
        row(1, 0, 0, 0,   0,           1, 0, 5,  0,             0, 1, 0, 5,   0,            0,  0, 0,            1, OB);
        row(0, 0, 0, 0,   0,           0, 0, 0,  0,             0, 0, 0, 0,   0,            0,  0, 0,            0, 0);
        row(0, 0, 0, 0,   0,           1, 1, BD, 32'hCAFEF00D,  0, 1, 1, BD,  32'hCAFEF00D, 0,  0, 0,            0, 0);
        row(0, 0, 0, 0,   0,           1, 0, BD, 0,             0, 1, 0, BD,  0,            0,  0, 0,            0, 0);
        row(0, 0, 0, 0,   0,           0, 0, 0,  0,             0, 0, 0, 0,   0,            0,  1, 32'hCAFEF00D, 0, 0);

        repeat (2) @(posedge clk);
        #1 preload = 1'b0;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1 drive(vecs[i]);
            #3;
            actual = {bus.cpu_stall, bus.dma_gnt, bus.mem_we, bus.mem_addr, bus.mem_wd, bus.cpu_rd,
                      bus.dma_rvalid, bus.dma_rd, bus.err_oob, bus.err_addr};
            n_checks++;
            if (actual !== vecs[i].exp) begin
                n_errors++;
                $display("FAIL row%0d: got %h expected %h (stall,gnt,mwe,maddr,mwd,crd,rvalid,drd,eoob,eaddr)",
                         i, actual, vecs[i].exp);
            end
        end

        // Starvation guard with a bounded wait: DMA must win on its fifth contested cycle
        win = -1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            reset = 1'b0;
            bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'd100; bus.cpu_wd = 32'd0;
            bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'd5;   bus.dma_wd = 32'd0;
            #3;
            if (bus.dma_gnt) begin
                win = k;
                break;
            end
        end
        chk("starve_win_cycle", 32'(win), 32'd4);
        chk("starve_cpu_stall", {31'd0, bus.cpu_stall}, 32'd1);

        @(posedge clk);
        #1 bus.dma_req = 1'b0;
        #3;
        chk("post_win_cpu_stall", {31'd0, bus.cpu_stall}, 32'd0);
        chk("post_win_cpu_rd", bus.cpu_rd, D);
        chk("post_win_rvalid", {31'd0, bus.dma_rvalid}, 32'd1);
        chk("post_win_dma_rd", bus.dma_rd, 32'h12);
        chk("oob_write_blocked", ram[64], 32'h0000_0BAD);
        chk("boundary_ram", ram[63], 32'hCAFEF00D);

        @(posedge clk);
        #1 bus.cpu_req = 1'b0;
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between two requesters: the pipeline memory stage (CPU port) and an image DMA engine that loads and dumps the 360x360 pixel buffer. The CPU port has priority, and a starvation counter guarantees the DMA port a slot. The block sits between the MEM stage / DMA engine and the data-memory RAM. It also flags and blocks out-of-range accesses.

Parameters:
DEPTH, 129600, number of 32-bit words in data memory (valid addresses 0..DEPTH-1)
STARVE_LIMIT, 4, consecutive cycles a pending DMA request may lose before it is forced to win (range 1..15)

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request (MEM stage holds a load/store)
cpu_we  in  1  CPU write enable
cpu_addr  in  32  CPU word address
cpu_wd  in  32  CPU write data
cpu_rd  out  32  CPU read data, same cycle as grant
cpu_stall  out  1  high when cpu_req is present but not granted this cycle
dma_req  in  1  DMA access request
dma_we  in  1  DMA write enable
dma_addr  in  32  DMA word address
dma_wd  in  32  DMA write data
dma_gnt  out  1  DMA granted this cycle; DMA may advance to next beat
dma_rvalid  out  1  registered read-data valid, one cycle after a DMA read grant
dma_rd  out  32  registered DMA read data
mem_we  out  1  to RAM write enable
mem_addr  out  32  to RAM address
mem_wd  out  32  to RAM write data
mem_rd  in  32  from RAM read data, valid within the addressed cycle
err_oob  out  1  sticky: an out-of-range access was attempted
err_addr  out  32  address of the first out-of-range access

Behaviour:
- Grant is combinational each cycle from the requests and registered starve_cnt (4 bits):
  - force = dma_req && starve_cnt >= STARVE_LIMIT.
  - DMA wins if force, or if dma_req && !cpu_req.
  - Otherwise CPU wins if cpu_req.
  - Otherwise idle.
- Winner's addr/wd drive mem_addr/mem_wd. mem_we = winner_we && in_range.
- Idle cycle: mem_we=0, mem_addr=0, mem_wd=0.
- in_range = addr < DEPTH (unsigned compare).
- cpu_stall = cpu_req && !cpu_grant. cpu_rd = mem_rd when cpu_grant && in_range, else 0.
- dma_gnt = dma_grant.
- On a DMA read grant: the next rising edge sets dma_rvalid=1 and dma_rd = (in_range ? mem_rd : 0). Otherwise dma_rvalid=0 next cycle and dma_rd holds its value.
- starve_cnt:
  - Cleared on any DMA grant or when dma_req=0.
  - Otherwise increments while dma_req && !dma_grant.
  - Saturates at 15.
- Requester protocol: each requester holds req/we/addr/wd stable until granted. Each grant is exactly one word access; the next request may follow in the next cycle.
- Out-of-range access (granted, addr >= DEPTH):
  - The write is suppressed; read returns 0.
  - The grant is still given, so the requester does not hang.
  - err_oob sets to 1 and stays set until reset. err_addr captures the address only on the first error.
  - If both ports have an error in the same cycle, only the granted one is recorded.
- Reset (synchronous, overrides everything in that cycle): starve_cnt=0, dma_rvalid=0, dma_rd=0, err_oob=0, err_addr=0. Grant outputs follow the combinational rule with starve_cnt=0.
- Reset mid-stream: a pending dma_rvalid is dropped, and the DMA must reissue.
- Simultaneous requests with starve_cnt < STARVE_LIMIT: CPU wins, DMA stalls, and starve_cnt increments.
- The block contains no other state.

Test Plan:
- Reset: assert reset one cycle with both requests high -> next cycle starve_cnt=0, dma_rvalid=0, err_oob=0; CPU granted, cpu_stall=0.
- CPU only: store addr 100 wd 0xDEADBEEF, then load addr 100 -> mem_we=1 on the store cycle; cpu_rd=0xDEADBEEF on the load cycle; cpu_stall=0 throughout.
- DMA read: dma_req read addr 5 (RAM holds 0x12) with cpu_req=0 -> dma_gnt=1 that cycle; next cycle dma_rvalid=1, dma_rd=0x12.
- Starvation: cpu_req held high, dma_req high -> DMA loses cycles 0..3 (cpu_stall=0) and wins cycle 4 (dma_gnt=1, cpu_stall=1); starve_cnt returns to 0.
- Out of range: CPU store to addr 129600 -> mem_we=0, err_oob=1, err_addr=129600; a later DMA access to 200000 leaves err_addr=129600.
- Boundary: DMA write then read at addr 129599 -> write lands, read returns the written data, err_oob stays 0.
